mcycle_div: RTL
===============

# mcycle_div

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the Execute stage beside the ALU and drives the `Busy` line that the hazard unit consumes to hold Fetch and Decode. On `Start` it accepts two operands, asserts `Busy` for the whole computation, then presents a registered `Result` with a one-cycle `Done` pulse.

## Interface
- `WIDTH`, 32, operand and result width in bits.
- `CLK`  in  1  rising-edge clock.
- `RESETn`  in  1  asynchronous active-low reset.
- `Start`  in  1  request; sampled only in IDLE or DONE.
- `Abort`  in  1  cancels an in-flight operation (driven by the Execute flush).
- `MCycleOp`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `Operand1`  in  WIDTH  dividend.
- `Operand2`  in  WIDTH  divisor.
- `Result`  out  WIDTH  quotient or remainder; valid when `Done`=1.
- `Busy`  out  1  pipeline hold request to the hazard unit.
- `Done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `Start`=1:
  - Latch `MCycleOp`.
  - Latch |Operand1| and |Operand2| (absolute values for signed ops).
  - Latch quotient sign (sign1 XOR sign2) and remainder sign (sign1), both for signed ops only.
  - Clear the partial remainder; load the iteration counter with WIDTH-1; go to RUN.
- RUN: each cycle performs one restoring step.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem (WIDTH+1 bits).
  - If non-negative, keep the difference and set quo[0]=1.
  - After WIDTH steps go to DONE.
- DONE:
  - Apply sign correction.
  - Register `Result`: quotient for ops 00/01, remainder for ops 10/11.
  - `Done`=1 for exactly this cycle.
  - Next state: RUN if `Start`=1 (back-to-back), otherwise IDLE.
- Special results follow the RISC-V spec and override the datapath:
  - Divisor 0: quotient all-ones, remainder = Operand1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- `Busy` is combinational: (`Start` & state∈{IDLE,DONE} & !`Abort`) | state==RUN. The pipeline therefore holds in the cycle the request arrives.
- `Start` while in RUN is ignored.
- `Abort` in any state forces IDLE next cycle, with no `Done`. `Abort` and `Start` in the same cycle: `Abort` wins.

## Timing
- Reset values:
  - State IDLE.
  - `Result`=0, `Done`=0, `Busy`=0 (given `Start`=0).
  - Counter and operand registers 0.
- Latency: `Start` in cycle 0 → RUN in cycles 1..WIDTH → DONE/`Done` in cycle WIDTH+1. That is 33 cycles for WIDTH=32.
- `Busy` is high in cycles 0..WIDTH and low in the DONE cycle, so the stalled instruction advances as `Result` appears.
- `Result` holds its value after DONE until the next DONE or reset.
- `RESETn` deasserted mid-RUN: immediate return to IDLE; `Busy` and `Done` drop asynchronously.
- Operands and `MCycleOp` are sampled only in the accept cycle; later changes have no effect.

## Configuration
- `MCYCLE_DIV_EARLY_OUT_EN` defined:
  - Divisor 0 or signed overflow, detected at accept, skips RUN and goes directly to DONE. Latency is 1 cycle (`Done` in cycle 1) and `Busy` is high only in cycle 0.
  - |Operand1| < |Operand2| also skips RUN: quotient 0, remainder = Operand1.
- Undefined: every operation takes the fixed WIDTH+1-cycle latency. Special results are still correct.

## Structure
- Shared package `mach_v_pkg`:
  - `MCycleOp` encodings (`MC_DIV`, `MC_DIVU`, `MC_REM`, `MC_REMU`).
  - Divider state enum.
  - `XLEN` constant.
- Sub-module `div_step`: combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem and quo. Instantiated once in `mcycle_div`.

## Test plan
- DIVU 100/7 → `Done` at cycle 33, `Result`=14; `Busy` high cycles 0–32. REMU with the same operands → 2.
- DIV -20/3 → 0xFFFFFFFA (-6). REM -20/3 → 0xFFFFFFFE (-2).
- DIV 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0.
- Back-to-back: `Start` in the DONE cycle of op A → op B `Done` exactly 33 cycles later; both results correct.
- `Abort` at cycle 10 of RUN → IDLE at cycle 11, no `Done`, `Busy` low. `Abort` and `Start` together → no operation starts.
- `RESETn` low mid-RUN → `Busy`/`Done`/`Result` 0 immediately. With `MCYCLE_DIV_EARLY_OUT_EN`, DIVU 3/0 → `Done` at cycle 1, `Result` 0xFFFFFFFF.

Source files
------------

// File: rtl/mach_v_pkg.sv
// Shared machine definitions for the multi-cycle execute units.
// Holds the MCycleOp encodings, the divider state type and the base data width.
package mach_v_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MC_DIV  = 2'b00;
    localparam logic [1:0] MC_DIVU = 2'b01;
    localparam logic [1:0] MC_REM  = 2'b10;
    localparam logic [1:0] MC_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic mc_is_signed(input logic [1:0] op);
        return (op == MC_DIV) || (op == MC_REM);
    endfunction

    function automatic logic mc_is_rem(input logic [1:0] op);
        return (op == MC_REM) || (op == MC_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division iteration on unsigned magnitudes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the outputs.
module div_step
    import mach_v_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_sh_rem;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // rem < divisor on entry, so the shifted value and the trial difference both fit in WIDTH+1 bits
    assign w_sh_rem = {i_rem, i_quo[WIDTH-1]};
    assign w_diff   = w_sh_rem - {1'b0, i_divisor};
    assign w_ge     = ~w_diff[WIDTH];

    assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_sh_rem[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mcycle_div.sv
// mcycle_div: iterative restoring divider for DIV/DIVU/REM/REMU; MCYCLE_DIV_EARLY_OUT_EN enables early finish.
// Latency: Start to Done is WIDTH+1 cycles (1 cycle for divide-by-zero/overflow/|a|<|b| when early-out is built in).
// Backpressure: Busy holds the pipeline from the accept cycle through the last RUN cycle; Start is ignored in RUN.
module mcycle_div
    import mach_v_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             Abort,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_div0;

    logic             w_signed;
    logic             w_s1;
    logic             w_s2;
    logic             w_div0;
    logic             w_can_accept;
    logic             w_early;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_early_res;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_quo_fin;
    logic [WIDTH-1:0] w_rem_fin;
    logic [WIDTH-1:0] w_final;

    assign w_signed     = mc_is_signed(MCycleOp);
    assign w_s1         = w_signed & Operand1[WIDTH-1];
    assign w_s2         = w_signed & Operand2[WIDTH-1];
    assign w_abs1       = w_s1 ? -Operand1 : Operand1;
    assign w_abs2       = w_s2 ? -Operand2 : Operand2;
    assign w_div0       = (Operand2 == '0);
    assign w_can_accept = (r_state == DIV_IDLE) || (r_state == DIV_DONE);

`ifdef MCYCLE_DIV_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_ovf;
    logic w_small;

    assign w_ovf   = w_signed && (Operand1 == SMIN) && (Operand2 == '1);
    assign w_small = (w_abs1 < w_abs2);
    assign w_early = w_div0 | w_ovf | w_small;

    always_comb begin
        w_early_res = '0;
        if (w_div0) begin
            w_early_res = mc_is_rem(MCycleOp) ? Operand1 : '1;
        end else if (w_ovf) begin
            w_early_res = mc_is_rem(MCycleOp) ? '0 : SMIN;
        end else begin
            w_early_res = mc_is_rem(MCycleOp) ? Operand1 : '0;
        end
    end
`else
    assign w_early     = 1'b0;
    assign w_early_res = '0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    // Divide by zero leaves an all-ones magnitude that must not be negated; overflow falls out naturally
    assign w_quo_fin = r_div0 ? '1 : (r_qneg ? -w_quo_nxt : w_quo_nxt);
    assign w_rem_fin = r_rneg ? -w_rem_nxt : w_rem_nxt;
    assign w_final   = mc_is_rem(r_op) ? w_rem_fin : w_quo_fin;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= DIV_IDLE;
            r_op     <= MC_DIV;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_div0   <= 1'b0;
            r_result <= '0;
        end else if (Abort) begin
            r_state <= DIV_IDLE;
        end else begin
            case (r_state)
                DIV_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt == '0) begin
                        r_state  <= DIV_DONE;
                        r_result <= w_final;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (Start && w_can_accept) begin
                        r_op   <= MCycleOp;
                        r_quo  <= w_abs1;
                        r_dvs  <= w_abs2;
                        r_rem  <= '0;
                        r_cnt  <= CW'(WIDTH - 1);
                        r_qneg <= w_s1 ^ w_s2;
                        r_rneg <= w_s1;
                        r_div0 <= w_div0;
                        if (w_early) begin
                            r_state  <= DIV_DONE;
                            r_result <= w_early_res;
                        end else begin
                            r_state <= DIV_RUN;
                        end
                    end else begin
                        r_state <= DIV_IDLE;
                    end
                end
            endcase
        end
    end

    assign Busy   = (Start && w_can_accept && !Abort) || (r_state == DIV_RUN);
    assign Done   = (r_state == DIV_DONE);
    assign Result = r_result;

endmodule
